intr_ctrl: RTL

- Interrupt controller on the mother_board, between the peripheral interrupt sources (uart rx/tx done, timer, etc.) and the cpu.
- Latches rising edges of each source into a pending bit and selects the highest-priority enabled pending source.
- Raises intr_req with a cause code to the cpu.
- Completes a four-phase handshake against the cpu's ack bit (intr[0], written by the w_intr instruction), clearing the serviced pending bit.

---
 rtl/intr_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches rising source edges into pending bits and requests the CPU for the
// highest-priority enabled source. Request rises 2 cycles after a sampled source edge; a four-phase ack clears it.
module intr_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               ack,
    input  logic               clr_ovf,
    output logic               intr_req,
    output logic [CAUSE_W-1:0] intr_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_SRC-1:0]   src_q;
    logic [NUM_SRC-1:0]   src_edge;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   clr;
    logic [NUM_SRC-1:0]   ovf_set;
    logic [CAUSE_W-1:0]   sel;

    always_comb begin
        src_edge = src & ~src_q;
        eligible = pending & mask;
        sel      = '0;
        clr      = '0;
        // Scan high to low so the lowest eligible index wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel = CAUSE_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = (state == REQ) && ack && (intr_cause == CAUSE_W'(i));
        end
        // A new edge in the clear cycle re-arms the bit rather than overflowing it.
        ovf_set = src_edge & pending & ~clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q    <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            src_q    <= src;
            pending  <= (pending & ~clr) | src_edge;
            overflow <= (overflow & ~{NUM_SRC{clr_ovf}}) | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            intr_req   <= 1'b0;
            intr_cause <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((eligible != '0) && !ack) begin
                        intr_cause <= sel;
                        intr_req   <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // Cause stays frozen until the CPU acks, even if the source gets masked.
                    if (ack) begin
                        intr_req <= 1'b0;
                        state    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    intr_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
